sys_arr_result_drain: RTL

SYS_ARR_RESULT_DRAIN -- requirements
Module: sys_arr_result_drain

---
 rtl/dsp_sys_arr_pkg.sv | 39 +++
 rtl/dirty_prio_enc.sv | 26 ++
 rtl/sys_arr_result_drain.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic-array DSP datapath and its result drain.
package dsp_sys_arr_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } single_float;

    typedef struct packed {
        single_float data;
        logic        dirty;
    } float_reg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } error;

    // Column index field wide enough for the largest supported array (16 columns).
    localparam int DRAIN_COL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    typedef struct packed {
        single_float            data;
        error                   err;
        logic [DRAIN_COL_W-1:0] col;
        logic                   last;
    } drain_beat_t;

endpackage

// File: rtl/dirty_prio_enc.sv
// Lowest-set-bit encoder: index, any-set flag and one-hot of the lowest set request bit.
module dirty_prio_enc #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any,
    output logic [N-1:0] onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = i[W-1:0];
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_arr_result_drain.sv
// Snapshots the array's per-column results and streams the dirty ones out in
// ascending column order over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for drain_start
// SNAP  | snapshot taken, lowest dirty column being selected
// DRAIN | presenting beats, one per accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE
module sys_arr_result_drain
    import dsp_sys_arr_pkg::*;
#(
    parameter int NUM_COLS = 4,
    localparam int CW = $clog2(NUM_COLS)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  float_reg [NUM_COLS-1:0] col_res,
    input  error     [NUM_COLS-1:0] col_err,
    input  logic                   drain_start,
    input  logic                   abort,
    input  logic                   out_ready,
    output logic                   out_valid,
    output word_t                  out_data,
    output logic [CW-1:0]          out_col,
    output error                   out_err,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output error                   err_sticky
);

    drain_state_e        state, state_nxt;
    single_float         snap_data [NUM_COLS];
    error                snap_err  [NUM_COLS];
    logic [NUM_COLS-1:0] mask;
    logic [NUM_COLS-1:0] dirty_in;
    logic [CW-1:0]       sel_idx;
    logic                sel_any;
    logic [NUM_COLS-1:0] sel_onehot;
    logic                xfer;
    drain_beat_t         beat;
    logic                unused_col_hi;

    dirty_prio_enc #(.N(NUM_COLS)) u_prio (
        .req    (mask),
        .idx    (sel_idx),
        .any    (sel_any),
        .onehot (sel_onehot)
    );

    // Gather the live dirty bits so the mask can be captured with the snapshot.
    always_comb begin
        dirty_in = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            dirty_in[i] = col_res[i].dirty;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (drain_start) state_nxt = SNAP;
                SNAP:    state_nxt = sel_any ? DRAIN : DONE;
                DRAIN:   if (xfer && beat.last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Current beat: the lowest remaining dirty column of the snapshot, zero outside DRAIN.
    always_comb begin
        beat = '0;
        if (state == DRAIN) begin
            beat.data = snap_data[sel_idx];
            beat.err  = snap_err[sel_idx];
            beat.col  = DRAIN_COL_W'(sel_idx);
            beat.last = (mask & ~sel_onehot) == '0;
        end
    end

    assign xfer = out_valid && out_ready;

    // Snapshot capture, mask retirement and sticky error accumulation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mask       <= '0;
            err_sticky <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                snap_data[i] <= '0;
                snap_err[i]  <= '0;
            end
        end else if (abort) begin
            mask <= '0;
        end else if (state == IDLE && drain_start) begin
            mask       <= dirty_in;
            err_sticky <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                snap_data[i] <= col_res[i].data;
                snap_err[i]  <= col_err[i];
            end
        end else if (xfer) begin
            mask       <= mask & ~sel_onehot;
            err_sticky <= err_sticky | beat.err;
        end
    end

    assign out_valid     = (state == DRAIN);
    assign out_data      = word_t'(beat.data);
    assign out_col       = beat.col[CW-1:0];
    assign out_err       = beat.err;
    assign out_last      = beat.last;
    assign busy          = (state == SNAP) || (state == DRAIN);
    assign done          = (state == DONE);
    // Column field is sized for the largest array; upper bits are zero here.
    assign unused_col_hi = ^beat.col;

endmodule
